seq_detect_prog: RTL and testbench
==================================

Name: seq_detect_prog

Overview:
Programmable serial bit-pattern detector; parametrised successor of the fixed "101" detector.
- Samples one bit per qualified clock.
- Compares the most recent cfg-length bits against a runtime-loaded pattern.
- Pulses z_out on each match and keeps a saturating match count.
- Supports overlapping and non-overlapping match modes.
- Sits on a serial monitor/debug path fed by any 1-bit stream.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of cfg_len; must hold MAX_LEN.
- CNT_W, 8, match counter width.
- RST_PATTERN, 8'b0000_0101, pattern after reset (LSB-aligned).
- RST_LEN, 3, pattern length after reset.
- RST_OVERLAP, 1, overlap mode after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- x_in  input  1  serial data bit.
- x_valid  input  1  x_in sampled only when high.
- cfg_we  input  1  load cfg_pattern/cfg_len/cfg_overlap this cycle.
- cfg_pattern  input  MAX_LEN  pattern, LSB-aligned; bit [len-1] is the first bit received.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1=overlapping matches, 0=non-overlapping.
- cnt_clr  input  1  synchronous clear of match_cnt.
- z_out  output  1  one-cycle match pulse.
- match_cnt  output  CNT_W  saturating number of matches.
- cfg_len_o  output  LEN_W  effective (clamped) length in use.

Behaviour:
Reset (async, reset=1):
- history=0, fill=0, z_out=0, match_cnt=0.
- pattern=RST_PATTERN, len=RST_LEN, overlap=RST_OVERLAP, cfg_len_o=RST_LEN.
- Reset mid-stream discards all partial progress; the first bit after release starts a fresh match.

Datapath:
- history is a MAX_LEN shift register; on x_valid: history <= {history[MAX_LEN-2:0], x_in}.
- fill counts valid bits since the last restart; saturates at MAX_LEN.

Match condition, evaluated on the post-shift values:
- x_valid=1 and fill_next >= len and history_next[len-1:0] == pattern[len-1:0].
- Only the low len bits are compared; upper pattern bits are ignored.

z_out:
- Registered; high for exactly the one cycle following the edge that samples the completing bit.
- 0 otherwise, including all x_valid=0 cycles. Bits with x_valid gaps still concatenate.

Overlap modes:
- overlap=1: fill keeps counting after a match, so trailing bits may begin the next match.
- overlap=0: on a match, fill_next is forced to 0; the next match needs len fresh bits.

Config load (cfg_we=1):
- Pattern, len and overlap are loaded at the edge.
- history, fill and z_out are cleared at the same edge.
- x_valid in the cfg_we cycle is ignored (no shift, no match).
- match_cnt is not affected.

Length rules:
- cfg_len > MAX_LEN is clamped to MAX_LEN.
- cfg_len = 0 or 1 is clamped to 2.
- cfg_len_o shows the clamped value.

match_cnt:
- Increments on each match; holds at 2^CNT_W-1 (no wrap).
- cnt_clr=1 clears it to 0; when cnt_clr and a match coincide, clear wins (result 0).
- z_out still pulses during a clear.

Timing:
- No combinational path from inputs to outputs.
- Single clock domain; all state is in flops reset by reset.

Test Plan:
1. Reset defaults, overlap=1, x_valid=1, stream 0,1,1,0,1,1,0,1,0,1,0 -> z_out pulses after bits 4, 7, 9 (0-indexed); match_cnt=3.
2. Same stream after cfg_we with pattern 101, len 3, overlap=0 -> pulses after bits 4 and 7 only; match_cnt=2 (cnt_clr first).
3. cfg pattern 8'b0000_1101, len 4: stream 1,1,0,1,1,0,1 -> overlap=1: pulses after bits 3 and 6, cnt=2; overlap=0: pulse after bit 3 only, cnt=1.
4. Stream 1,0,1 with x_valid=0 for 3 cycles between each bit -> one z_out pulse, one cycle wide, after the final 1. Then cfg_len=12 -> cfg_len_o=8; cfg_len=0 -> cfg_len_o=2.
5. CNT_W=2 build, 5 matches of 101 in overlap mode -> match_cnt 1,2,3,3,3. cnt_clr asserted on the 6th match cycle -> z_out=1, match_cnt=0.
6. Feed 1,0 then assert reset for 1 cycle mid-clock, release, feed 1 -> no pulse. Then 0,1 -> pulse. Config cycle with x_valid=1, x_in=1 -> bit ignored and fill=0.

Source files
------------

// File: rtl/seq_detect_prog_if.sv
// seq_detect_prog_if
//   Bundles the serial data, configuration and result signals of the
//   programmable sequence detector.
//   master : stream/config source (drives x_*, cfg_*, cnt_clr; reads results)
//   slave  : detector (reads x_*, cfg_*, cnt_clr; drives z_out, match_cnt, cfg_len_o)
interface seq_detect_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               x_in;
    logic               x_valid;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               z_out;
    logic [CNT_W-1:0]   match_cnt;
    logic [LEN_W-1:0]   cfg_len_o;

    modport master (
        output x_in, x_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  z_out, match_cnt, cfg_len_o
    );

    modport slave (
        input  x_in, x_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output z_out, match_cnt, cfg_len_o
    );
endinterface

// File: rtl/seq_detect_prog.sv
// seq_detect_prog
//   Programmable serial bit-pattern detector. Samples x_in whenever x_valid
//   is high, compares the most recent len bits against a runtime-loaded
//   pattern, pulses z_out for one cycle per match and keeps a saturating
//   match count. Overlapping or non-overlapping matching is selectable.
// Ports
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : slave side of seq_detect_prog_if
//           in : x_in, x_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr
//           out: z_out (registered pulse), match_cnt, cfg_len_o (clamped length)
module seq_detect_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_0101),
    parameter int                 RST_LEN     = 3,
    parameter bit                 RST_OVERLAP = 1'b1
) (
    input logic              clk,
    input logic              reset,
    seq_detect_prog_if.slave bus
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(2);
    localparam int               RST_LEN_I = (RST_LEN > MAX_LEN) ? MAX_LEN :
                                             (RST_LEN < 2)       ? 2 : RST_LEN;
    localparam logic [LEN_W-1:0] RST_LEN_L = LEN_W'(RST_LEN_I);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l > MAX_LEN_L)
            return MAX_LEN_L;
        else if (l < MIN_LEN_L)
            return MIN_LEN_L;
        else
            return l;
    endfunction

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    // Only MAX_LEN-1 past bits are stored: together with the incoming bit
    // they form the full MAX_LEN-bit window that is compared, and the oldest
    // bit would fall out on the very shift that could use it.
    logic [MAX_LEN-2:0] history_q;
    logic [LEN_W-1:0]   fill_q;
    logic               z_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [MAX_LEN-1:0] history_next;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;

    assign history_next = {history_q, bus.x_in};
    assign fill_inc     = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + LEN_W'(1);

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            len_mask[i] = (LEN_W'(i) < len_q);
    end

    // A config load owns the cycle: the bit offered alongside it is dropped.
    assign match = bus.x_valid && !bus.cfg_we && (fill_inc >= len_q) &&
                   ((history_next & len_mask) == (pattern_q & len_mask));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= RST_PATTERN;
            len_q     <= RST_LEN_L;
            overlap_q <= RST_OVERLAP;
            history_q <= '0;
            fill_q    <= '0;
            z_q       <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (bus.cfg_we) begin
                pattern_q <= bus.cfg_pattern;
                len_q     <= clamp_len(bus.cfg_len);
                overlap_q <= bus.cfg_overlap;
                history_q <= '0;
                fill_q    <= '0;
                z_q       <= 1'b0;
            end else begin
                z_q <= match;
                if (bus.x_valid) begin
                    history_q <= history_next[MAX_LEN-2:0];
                    // Non-overlapping: restart the fill so the next match
                    // needs len fresh bits.
                    fill_q    <= (match && !overlap_q) ? '0 : fill_inc;
                end
            end

            if (bus.cnt_clr)
                cnt_q <= '0;
            else if (match && (cnt_q != CNT_MAX))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.z_out     = z_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cfg_len_o = len_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog
//   Directed bench for seq_detect_prog. Two instances share one stimulus:
//   dut_a uses the default 8-bit counter, dut_b a 2-bit counter so that
//   saturation can be observed. Each expected pulse is queued with the
//   cycle it must appear in and both expected counts; the monitor pops
//   entries as pulses appear and flags missing, late or extra pulses.
module tb_seq_detect_prog;

    logic       clk;
    logic       reset;
    logic       x_in;
    logic       x_valid;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       cnt_clr;

    seq_detect_prog_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) bus_a ();
    seq_detect_prog_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) bus_b ();

    assign bus_a.x_in        = x_in;
    assign bus_a.x_valid     = x_valid;
    assign bus_a.cfg_we      = cfg_we;
    assign bus_a.cfg_pattern = cfg_pattern;
    assign bus_a.cfg_len     = cfg_len;
    assign bus_a.cfg_overlap = cfg_overlap;
    assign bus_a.cnt_clr     = cnt_clr;

    assign bus_b.x_in        = x_in;
    assign bus_b.x_valid     = x_valid;
    assign bus_b.cfg_we      = cfg_we;
    assign bus_b.cfg_pattern = cfg_pattern;
    assign bus_b.cfg_len     = cfg_len;
    assign bus_b.cfg_overlap = cfg_overlap;
    assign bus_b.cnt_clr     = cnt_clr;

    seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ca;
        int cb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   neg_n  = 0;
    int   ea     = 0;
    int   eb     = 0;

    // Monitor: every falling edge, a pulse on either DUT or a due entry
    // in the queue produces one comparison.
    always @(negedge clk) begin
        exp_t e;
        logic due;
        neg_n = neg_n + 1;
        due = 1'b0;
        if (sb.size() > 0)
            due = (sb[0].cyc <= neg_n);
        if (due || bus_a.z_out || bus_b.z_out) begin
            checks = checks + 1;
            if (!due) begin
                errors = errors + 1;
                $display("FAIL unexpected_pulse cycle=%0d z_a=%0b z_b=%0b required no pulse",
                         neg_n, bus_a.z_out, bus_b.z_out);
            end else begin
                e = sb.pop_front();
                if (e.cyc != neg_n || bus_a.z_out !== 1'b1 || bus_b.z_out !== 1'b1 ||
                    int'(bus_a.match_cnt) != e.ca || int'(bus_b.match_cnt) != e.cb) begin
                    errors = errors + 1;
                    $display("FAIL pulse cycle=%0d got z_a=%0b z_b=%0b cnt_a=%0d cnt_b=%0d required pulse at %0d cnt_a=%0d cnt_b=%0d",
                             neg_n, bus_a.z_out, bus_b.z_out, bus_a.match_cnt, bus_b.match_cnt,
                             e.cyc, e.ca, e.cb);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0d required=%0d", name, act, exp);
        end
    endtask

    // One clock of stimulus; exp_z says this bit must complete a match.
    task automatic step(input logic b, input logic v, input logic exp_z, input logic clr);
        x_in    = b;
        x_valid = v;
        cnt_clr = clr;
        cfg_we  = 1'b0;
        @(posedge clk);
        #1;
        if (clr) begin
            ea = 0;
            eb = 0;
        end else if (exp_z) begin
            ea = ea + 1;
            if (eb < 3) eb = eb + 1;
        end
        if (exp_z) sb.push_back('{neg_n + 1, ea, eb});
        x_valid = 1'b0;
        cnt_clr = 1'b0;
    endtask

    // bits[i] is the i-th bit sent; pz[i] marks bits that complete a match.
    task automatic feed(input logic [15:0] bits, input logic [15:0] pz, input int n);
        for (int i = 0; i < n; i++)
            step(bits[i], 1'b1, pz[i], 1'b0);
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                       input logic xv, input logic xb);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        x_valid     = xv;
        x_in        = xb;
        cfg_we      = 1'b1;
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
        x_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_cnt();
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        x_in        = 1'b0;
        x_valid     = 1'b0;
        cfg_we      = 1'b0;
        cfg_pattern = 8'h00;
        cfg_len     = 4'd0;
        cfg_overlap = 1'b0;
        cnt_clr     = 1'b0;
        #12;
        check("reset_z", int'(bus_a.z_out), 0);
        check("reset_cnt", int'(bus_a.match_cnt), 0);
        check("reset_len", int'(bus_a.cfg_len_o), 3);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: defaults (101, len 3, overlap): pulses after bits 4, 7, 9
        feed(16'h02B6, 16'h0290, 11);
        idle(2);
        check("t1_cnt", int'(bus_a.match_cnt), 3);
        check("t1_cnt_b", int'(bus_b.match_cnt), 3);

        // 2: same stream, non-overlapping: pulses after bits 4, 7
        clear_cnt();
        cfg(8'b0000_0101, 4'd3, 1'b0, 1'b0, 1'b0);
        feed(16'h02B6, 16'h0090, 11);
        idle(2);
        check("t2_cnt", int'(bus_a.match_cnt), 2);

        // 3: pattern 1101, stream 1,1,0,1,1,0,1
        clear_cnt();
        cfg(8'b0000_1101, 4'd4, 1'b1, 1'b0, 1'b0);
        feed(16'h005B, 16'h0048, 7);
        idle(2);
        check("t3_ovl_cnt", int'(bus_a.match_cnt), 2);
        clear_cnt();
        cfg(8'b0000_1101, 4'd4, 1'b0, 1'b0, 1'b0);
        feed(16'h005B, 16'h0008, 7);
        idle(2);
        check("t3_novl_cnt", int'(bus_a.match_cnt), 1);

        // 4: bits separated by invalid cycles carrying junk
        cfg(8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b0);
        clear_cnt();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        idle(3);
        check("t4_gap_cnt", int'(bus_a.match_cnt), 1);

        // Length clamping; len 12 -> 8 with a full 8-bit pattern
        cfg(8'b1011_0010, 4'd12, 1'b1, 1'b0, 1'b0);
        check("t4_len12", int'(bus_a.cfg_len_o), 8);
        check("t4_cfg_keeps_cnt", int'(bus_a.match_cnt), 1);
        feed(16'h004D, 16'h0080, 8);
        idle(2);
        check("t4_len8_cnt", int'(bus_a.match_cnt), 2);
        // len 0 -> 2; only pattern bits [1:0] = 01 count
        cfg(8'b1111_1101, 4'd0, 1'b1, 1'b0, 1'b0);
        check("t4_len0", int'(bus_a.cfg_len_o), 2);
        feed(16'h000A, 16'h000A, 4);
        idle(2);
        check("t4_len2_cnt", int'(bus_a.match_cnt), 4);
        cfg(8'b0000_0101, 4'd1, 1'b1, 1'b0, 1'b0);
        check("t4_len1", int'(bus_a.cfg_len_o), 2);
        cfg(8'b0000_0101, 4'd8, 1'b1, 1'b0, 1'b0);
        check("t4_len8", int'(bus_a.cfg_len_o), 8);

        // 5: five overlapping 101 matches, then a match coinciding with clear
        clear_cnt();
        cfg(8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b0);
        feed(16'h0555, 16'h0554, 11);
        check("t5_cnt_a", int'(bus_a.match_cnt), 5);
        check("t5_cnt_b_sat", int'(bus_b.match_cnt), 3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("t5_clr_wins_a", int'(bus_a.match_cnt), 0);
        check("t5_clr_wins_b", int'(bus_b.match_cnt), 0);
        idle(2);

        // 6: reset mid-stream discards progress
        cfg(8'b0001_0110, 4'd5, 1'b0, 1'b0, 1'b0);
        feed(16'h0001, 16'h0000, 2);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("t6_rst_z", int'(bus_a.z_out), 0);
        reset = 1'b0;
        ea = 0;
        eb = 0;
        check("t6_rst_len", int'(bus_a.cfg_len_o), 3);
        check("t6_rst_cnt", int'(bus_a.match_cnt), 0);
        feed(16'h0001, 16'h0000, 1);
        feed(16'h0002, 16'h0002, 2);
        idle(1);
        // config cycle carrying a valid 1: the bit must be dropped
        cfg(8'b0000_0101, 4'd3, 1'b1, 1'b1, 1'b1);
        check("t6_cfg_cnt", int'(bus_a.match_cnt), 1);
        feed(16'h000A, 16'h0008, 4);
        idle(1);
        // fill restarts on config: pattern 001 must not match the first bit
        cfg(8'b0000_0001, 4'd3, 1'b1, 1'b0, 1'b0);
        feed(16'h0009, 16'h0008, 4);
        idle(3);
        check("t6_final_cnt", int'(bus_a.match_cnt), 3);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
